instruction_fetcher: RTL and testbench

- Fetch-side requester for the memory controller's fetch port: issues one-word fetches at the current fetch PC and collects returned instructions.
- Returned instructions and their PCs are pushed into an in-order instruction queue (IQ), which is popped by the issue/dispatch stage.
- Redirects the fetch PC on roll_back and flushes the queue.
- At most one fetch is outstanding at any time.

---
 rtl/instruction_fetcher_pkg.sv | 14 +
 rtl/instruction_fetcher_iq_fifo.sv | 42 ++++
 rtl/instruction_fetcher.sv | 87 ++++++++
 tb/tb_instruction_fetcher.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: shared constants, FSM encoding and IQ entry type for the fetch unit
`ifndef IQ_IDX
`define IQ_IDX(lg) [(lg)-1:0]
`endif
package instruction_fetcher_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;
endpackage

// File: rtl/instruction_fetcher_iq_fifo.sv
// iq_fifo: circular buffer of {inst,pc} entries with push/pop/flush, count, valid and full
module iq_fifo
  import instruction_fetcher_pkg::*;
#(
  parameter int DEPTH_LOG = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  iq_entry_t          din,
  output iq_entry_t          dout,
  output logic               valid,
  output logic               full,
  output logic [DEPTH_LOG:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  iq_entry_t mem [DEPTH];
  logic `IQ_IDX(DEPTH_LOG) head, tail;
  logic do_pop;
  assign valid = count != '0;
  assign full = count == (DEPTH_LOG + 1)'(DEPTH);
  assign do_pop = pop && valid;
  assign dout = valid ? mem[head] : '0;
  always_ff @(posedge clk_in)
    if (!rst_in && en && !flush && push) mem[tail] <= din;
  always_ff @(posedge clk_in) begin
    if (rst_in || (en && flush)) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (en) begin
      if (push) tail <= tail + 1'b1;
      if (do_pop) head <= head + 1'b1;
      count <= count + (DEPTH_LOG + 1)'(push) - (DEPTH_LOG + 1)'(do_pop);
    end
  end
  // the fetcher never requests while full, so a push needs space unless the head leaves too
  assert property (@(posedge clk_in) disable iff (rst_in) !(en && !flush && push && full && !do_pop));
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: single-outstanding fetch requester feeding an in-order instruction queue
// FETCH_JAL_PREDICT_EN: when defined, a fetched JAL redirects the next fetch PC to its target
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH_LOG = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [31:0] rollback_pc,
  output logic        fetch_start,
  output logic [31:0] pc,
  input  logic        finish_fetch,
  input  logic [31:0] instruction_out,
  input  logic [31:0] instruction_pc_out,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  input  logic        iq_pop,
  output logic        iq_full
);
  state_t state, state_n;
  logic [31:0] pc_n, next_pc;
  logic push, can_issue;
  logic [IQ_DEPTH_LOG:0] count;
  iq_entry_t head;
  iq_fifo #(.DEPTH_LOG(IQ_DEPTH_LOG)) u_iq (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en(rdy_in),
    .flush(roll_back),
    .push(push),
    .pop(iq_pop),
    .din('{inst: instruction_out, pc: pc}),
    .dout(head),
    .valid(iq_valid),
    .full(iq_full),
    .count(count)
  );
  assign iq_inst = head.inst;
  assign iq_pc = head.pc;
  assign fetch_start = state == REQ;
  assign can_issue = count < (IQ_DEPTH_LOG + 1)'(1 << IQ_DEPTH_LOG);
`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] inst_q;
  always_ff @(posedge clk_in)
    if (rst_in) inst_q <= '0;
    else if (rdy_in && !roll_back && push) inst_q <= instruction_out;
  assign next_pc = inst_q[6:0] == OPC_JAL
    ? pc + {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}
    : pc + 32'd4;
`else
  assign next_pc = pc + 32'd4;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    push = FALSE;
    case (state)
      IDLE: state_n = can_issue ? REQ : IDLE;
      REQ: if (finish_fetch) begin
        push = instruction_pc_out == pc;
        state_n = push ? HOLD : IDLE;
      end
      HOLD: begin
        pc_n = next_pc;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      pc <= RESET_PC;
    end else if (rdy_in) begin
      state <= roll_back ? IDLE : state_n;
      pc <= roll_back ? rollback_pc : pc_n;
    end
  end
  // a returned word must belong to the address currently being requested
  assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !roll_back && state == REQ && finish_fetch) |-> instruction_pc_out == pc);
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed stimulus with a memory-controller model and a pop-side scoreboard
module tb_instruction_fetcher;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic roll_back = 1'b0;
  logic [31:0] rollback_pc = '0;
  logic finish_fetch = 1'b0;
  logic [31:0] instruction_out = '0;
  logic [31:0] instruction_pc_out = '0;
  logic iq_pop = 1'b0;
  logic fetch_start, iq_valid, iq_full;
  logic [31:0] pc, iq_inst, iq_pc;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt = 0;
  int lat = 5;
  logic ctl_en = 1'b0;
  logic jal_mode = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk_in = ~clk_in;

  instruction_fetcher dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .roll_back(roll_back),
    .rollback_pc(rollback_pc),
    .fetch_start(fetch_start),
    .pc(pc),
    .finish_fetch(finish_fetch),
    .instruction_out(instruction_out),
    .instruction_pc_out(instruction_pc_out),
    .iq_valid(iq_valid),
    .iq_inst(iq_inst),
    .iq_pc(iq_pc),
    .iq_pop(iq_pop),
    .iq_full(iq_full)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (jal_mode && a == 32'h20) ? 32'h0100006F : ((a << 20) | 32'h13);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_fs(input logic v, input string name);
    for (int k = 0; k < 200 && fetch_start !== v; k++) tick;
    chk(name, 32'(fetch_start), 32'(v));
  endtask

  task automatic wait_full(input string name);
    for (int k = 0; k < 600 && iq_full !== 1'b1; k++) tick;
    chk(name, 32'(iq_full), 32'd1);
  endtask

  task automatic arm(input int target, input string name);
    for (int k = 0; k < 200 && !(fetch_start === 1'b1 && cnt == target); k++) tick;
    chk(name, 32'(fetch_start === 1'b1 && cnt == target), 32'd1);
  endtask

  // memory controller model: answers each request after lat cycles
  always @(negedge clk_in) begin
    finish_fetch = 1'b0;
    if (ctl_en && rdy_in && fetch_start) begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        finish_fetch = 1'b1;
        instruction_out = word_at(pc);
        instruction_pc_out = pc;
        if (!roll_back) exp_q.push_back({instruction_out, pc});
      end
    end else if (!fetch_start) cnt = 0;
  end

  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && !roll_back && iq_pop && iq_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h expected no entry", iq_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_inst", iq_inst, mon_e[63:32]);
        chk("pop_pc", iq_pc, mon_e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) tick;
    chk("rst_fetch_start", 32'(fetch_start), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_iq_valid", 32'(iq_valid), 32'd0);
    chk("rst_iq_full", 32'(iq_full), 32'd0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    chk("rst_iq_pc", iq_pc, 32'h0);
    rst_in = 1'b0;
    ctl_en = 1'b1;
    wait_fs(1'b1, "t1_req");
    chk("t1_req_pc", pc, 32'h0);
    wait_fs(1'b0, "t1_hold");
    chk("t1_hold_pc", pc, 32'h0);
    chk("t1_head_inst", iq_inst, 32'h13);
    chk("t1_head_pc", iq_pc, 32'h0);
    tick;
    chk("t1_idle_fs", 32'(fetch_start), 32'd0);
    chk("t1_idle_pc", pc, 32'h4);
    wait_fs(1'b1, "t1_req2");
    chk("t1_req2_pc", pc, 32'h4);
    wait_full("t2_full");
    repeat (3) tick;
    chk("t2_fs", 32'(fetch_start), 32'd0);
    chk("t2_pc", pc, 32'h40);
    chk("t2_still_full", 32'(iq_full), 32'd1);
    chk("t2_head_pc", iq_pc, 32'h0);
    iq_pop = 1'b1;
    tick;
    iq_pop = 1'b0;
    chk("t3_pop_pc", iq_pc, 32'h4);
    chk("t3_pop_full", 32'(iq_full), 32'd0);
    arm(lat - 1, "t3_arm");
    iq_pop = 1'b1;
    tick;
    iq_pop = 1'b0;
    chk("t3_pushpop_pc", iq_pc, 32'h8);
    chk("t3_pushpop_full", 32'(iq_full), 32'd0);
    wait_full("t3_refull");
    iq_pop = 1'b1;
    tick;
    iq_pop = 1'b0;
    arm(lat - 1, "t4_arm");
    roll_back = 1'b1;
    rollback_pc = 32'h100;
    iq_pop = 1'b1;
    exp_q.delete();
    tick;
    roll_back = 1'b0;
    iq_pop = 1'b0;
    chk("t4_iq_valid", 32'(iq_valid), 32'd0);
    chk("t4_iq_full", 32'(iq_full), 32'd0);
    chk("t4_fs", 32'(fetch_start), 32'd0);
    chk("t4_pc", pc, 32'h100);
    wait_fs(1'b1, "t4_req");
    chk("t4_req_pc", pc, 32'h100);
    wait_fs(1'b0, "t5_hold");
    wait_fs(1'b1, "t5_req");
    arm(1, "t5_arm");
    rdy_in = 1'b0;
    iq_pop = 1'b1;
    repeat (3) tick;
    chk("t5_fs", 32'(fetch_start), 32'd1);
    chk("t5_pc", pc, 32'h104);
    chk("t5_iq_valid", 32'(iq_valid), 32'd1);
    chk("t5_iq_pc", iq_pc, 32'h100);
    rdy_in = 1'b1;
    iq_pop = 1'b0;
    wait_fs(1'b0, "t5_resume_hold");
    chk("t5_resume_pc", pc, 32'h104);
    chk("t5_resume_head", iq_pc, 32'h100);
    roll_back = 1'b1;
    rollback_pc = 32'h20;
    jal_mode = 1'b1;
    exp_q.delete();
    tick;
    roll_back = 1'b0;
    wait_fs(1'b1, "t6_req");
    chk("t6_req_pc", pc, 32'h20);
    wait_fs(1'b0, "t6_hold");
    wait_fs(1'b1, "t6_next_req");
`ifdef FETCH_JAL_PREDICT_EN
    chk("t6_next_pc", pc, 32'h30);
`else
    chk("t6_next_pc", pc, 32'h24);
`endif
    ctl_en = 1'b0;
    iq_pop = 1'b1;
    repeat (5) tick;
    iq_pop = 1'b0;
    chk("drain_iq_valid", 32'(iq_valid), 32'd0);
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
